// File: rtl/rom_sprite_walker_if.sv
`default_nettype none
// ============================================================================
// Module      : rom_sprite_walker_if
// Description : Point stream from the sprite walker to the vector drawer.
//               master = walker (drives the point), slave = drawer (ready).
//   pt_valid  point valid           pt_ready  drawer accepts the point
//   pt_x/y    translated coordinate pt_pen    1 = draw, 0 = move beam
//   pt_clip   point clamped to edge pt_last   final point of the image
// Revision    : 1.0 - initial release
// ============================================================================
interface rom_sprite_walker_if #(
    parameter int COORD_W = 8
);
    logic               pt_valid;
    logic               pt_ready;
    logic [COORD_W-1:0] pt_x;
    logic [COORD_W-1:0] pt_y;
    logic               pt_pen;
    logic               pt_clip;
    logic               pt_last;

    modport master (
        output pt_valid, pt_x, pt_y, pt_pen, pt_clip, pt_last,
        input  pt_ready
    );

    modport slave (
        input  pt_valid, pt_x, pt_y, pt_pen, pt_clip, pt_last,
        output pt_ready
    );
endinterface
`default_nettype wire

// File: rtl/rom_sprite_walker.sv
`default_nettype none
// ============================================================================
// Module      : rom_sprite_walker
// Description : Walks the vector-image ROM one word per point, translates
//               each point so the image mid-point lands on the requested
//               screen position, clamps it to the screen and hands it to
//               the vector drawer with pen state.
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request pulse (sampled only when idle)
//   img_adr         image start address in ROM
//   pos_x/pos_y     screen position of the image mid-point
//   mid_x/mid_y     image mid-point
//   busy/done/err   walk in progress / walk finished / point guard tripped
//   rom_adr         ROM read address
//   rom_data        ROM word one cycle after rom_adr:
//                   [17] last, [16] pen, [15:8] x, [7:0] y
//   pt              point stream to the drawer (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module rom_sprite_walker #(
    parameter int ADR_W      = 10,
    parameter int COORD_W    = 8,
    parameter int MAX_POINTS = 64
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               start,
    input  wire logic [ADR_W-1:0]   img_adr,
    input  wire logic [COORD_W-1:0] pos_x,
    input  wire logic [COORD_W-1:0] pos_y,
    input  wire logic [COORD_W-1:0] mid_x,
    input  wire logic [COORD_W-1:0] mid_y,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [ADR_W-1:0]        rom_adr,
    input  wire logic [17:0]        rom_data,
    rom_sprite_walker_if.master     pt
);

    localparam int c_CNT_W = (MAX_POINTS > 2) ? $clog2(MAX_POINTS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAX_POINTS - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_FETCH = 2'd1;
    localparam logic [1:0] c_S_WAIT  = 2'd2;
    localparam logic [1:0] c_S_EMIT  = 2'd3;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [COORD_W-1:0] r_pos_x, r_pos_y, r_mid_x, r_mid_y;
    logic               r_pt_valid, r_pt_pen, r_pt_clip, r_pt_last;
    logic [COORD_W-1:0] r_pt_x, r_pt_y;
    logic [COORD_W:0]   w_tx, w_ty;   // {clip, coordinate}

    // pos + coord - mid evaluated two bits wider than the screen so that the
    // top bit is the sign (below 0) and the next one flags overflow (> max).
    function automatic logic [COORD_W:0] f_xlate(
        input logic [COORD_W-1:0] p,
        input logic [7:0]         c,
        input logic [COORD_W-1:0] m
    );
        logic [COORD_W+1:0] t;
        t = {2'b00, p} + {{(COORD_W-6){1'b0}}, c} - {2'b00, m};
        if (t[COORD_W+1])
            f_xlate = {1'b1, {COORD_W{1'b0}}};
        else if (t[COORD_W])
            f_xlate = {1'b1, {COORD_W{1'b1}}};
        else
            f_xlate = {1'b0, t[COORD_W-1:0]};
    endfunction

    always_comb begin
        w_tx = f_xlate(r_pos_x, rom_data[15:8], r_mid_x);
        w_ty = f_xlate(r_pos_y, rom_data[7:0],  r_mid_y);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_S_IDLE;
            r_cnt      <= '0;
            r_pos_x    <= '0;
            r_pos_y    <= '0;
            r_mid_x    <= '0;
            r_mid_y    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            rom_adr    <= '0;
            r_pt_valid <= 1'b0;
            r_pt_x     <= '0;
            r_pt_y     <= '0;
            r_pt_pen   <= 1'b0;
            r_pt_clip  <= 1'b0;
            r_pt_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_pos_x <= pos_x;
                        r_pos_y <= pos_y;
                        r_mid_x <= mid_x;
                        r_mid_y <= mid_y;
                        rom_adr <= img_adr;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= c_S_FETCH;
                    end
                end
                c_S_FETCH: begin
                    r_state <= c_S_WAIT;
                end
                c_S_WAIT: begin
                    r_pt_x     <= w_tx[COORD_W-1:0];
                    r_pt_y     <= w_ty[COORD_W-1:0];
                    r_pt_clip  <= w_tx[COORD_W] | w_ty[COORD_W];
                    r_pt_pen   <= rom_data[16];
                    r_pt_last  <= rom_data[17];
                    r_pt_valid <= 1'b1;
                    r_state    <= c_S_EMIT;
                end
                c_S_EMIT: begin
                    if (pt.pt_ready) begin
                        r_pt_valid <= 1'b0;
                        // A real last flag wins over the guard on the same point.
                        if (r_pt_last || (r_cnt == c_CNT_LAST)) begin
                            done    <= 1'b1;
                            err     <= ~r_pt_last;
                            busy    <= 1'b0;
                            r_state <= c_S_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            rom_adr <= rom_adr + 1'b1;
                            r_state <= c_S_FETCH;
                        end
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign pt.pt_valid = r_pt_valid;
    assign pt.pt_x     = r_pt_x;
    assign pt.pt_y     = r_pt_y;
    assign pt.pt_pen   = r_pt_pen;
    assign pt.pt_clip  = r_pt_clip;
    assign pt.pt_last  = r_pt_last;

endmodule
`default_nettype wire

// File: tb/tb_rom_sprite_walker.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_sprite_walker
// Description : Scoreboard bench for rom_sprite_walker. Stimulus pushes the
//               hand-computed points and completion status into queues; a
//               monitor pops and compares on every point handshake and done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_sprite_walker;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       pen;
        logic       clip;
        logic       last;
    } pt_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  img_adr = '0;
    logic [7:0]  pos_x = '0, pos_y = '0, mid_x = '0, mid_y = '0;
    logic        busy, done, err;
    logic [9:0]  rom_adr;
    logic [17:0] rom_data = '0;
    logic [17:0] rom_mem [0:1023];

    int checks = 0;
    int errors = 0;
    pt_t  sb_pt [$];
    logic sb_err [$];

    rom_sprite_walker_if #(.COORD_W(8)) u_pt_if ();

    rom_sprite_walker #(
        .ADR_W      (10),
        .COORD_W    (8),
        .MAX_POINTS (4)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .img_adr  (img_adr),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .mid_x    (mid_x),
        .mid_y    (mid_y),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rom_adr  (rom_adr),
        .rom_data (rom_data),
        .pt       (u_pt_if)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: word appears one cycle after its address.
    always @(posedge clk) rom_data <= rom_mem[rom_adr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] w(input logic last, input logic pen,
                                      input logic [7:0] x, input logic [7:0] y);
        return {last, pen, x, y};
    endfunction

    function automatic pt_t mk(input logic [7:0] x, input logic [7:0] y,
                               input logic pen, input logic clip, input logic last);
        return '{x: x, y: y, pen: pen, clip: clip, last: last};
    endfunction

    task automatic issue(input logic [9:0] a, input logic [7:0] px, input logic [7:0] py,
                         input logic [7:0] mx, input logic [7:0] my);
        @(posedge clk); #1;
        img_adr = a; pos_x = px; pos_y = py; mid_x = mx; mid_y = my;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_valid(input string name, input int bound);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (u_pt_if.pt_valid) seen = 1'b1;
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    // Monitor: points on handshake, completion on done, stability under stall.
    initial begin
        pt_t        cur, held_pt, e;
        logic       held;
        logic [9:0] held_adr;
        logic       ee;
        held = 1'b0;
        held_pt = '0;
        held_adr = '0;
        forever begin
            @(negedge clk);
            cur = mk(u_pt_if.pt_x, u_pt_if.pt_y, u_pt_if.pt_pen, u_pt_if.pt_clip, u_pt_if.pt_last);
            if (held && u_pt_if.pt_valid) begin
                chk("stall_point_stable", {13'd0, cur}, {13'd0, held_pt});
                chk("stall_rom_adr_stable", {22'd0, rom_adr}, {22'd0, held_adr});
            end
            if (u_pt_if.pt_valid && u_pt_if.pt_ready) begin
                held = 1'b0;
                if (sb_pt.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_point actual=%h required=none", cur);
                end else begin
                    e = sb_pt.pop_front();
                    chk("point", {13'd0, cur}, {13'd0, e});
                end
            end else if (u_pt_if.pt_valid) begin
                held = 1'b1;
                held_pt = cur;
                held_adr = rom_adr;
            end else begin
                held = 1'b0;
            end
            if (done) begin
                if (sb_err.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    ee = sb_err.pop_front();
                    chk("done_err", {31'd0, err}, {31'd0, ee});
                    chk("busy_at_done", {31'd0, busy}, 32'd0);
                end
            end else if (err) begin
                checks++; errors++;
                $display("FAIL err_without_done actual=1 required=0");
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom_mem[i] = '0;
        u_pt_if.pt_ready = 1'b1;

        // Reset state
        #3;
        chk("reset_outputs",
            {9'd0, busy, done, err, rom_adr, u_pt_if.pt_valid, u_pt_if.pt_pen,
             u_pt_if.pt_clip, u_pt_if.pt_last},
            32'd0);
        chk("reset_xy", {16'd0, u_pt_if.pt_x, u_pt_if.pt_y}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Basic two-point image with latency check
        rom_mem[517] = w(1'b0, 1'b0, 8'd32, 8'd40);
        rom_mem[518] = w(1'b1, 1'b1, 8'd40, 8'd40);
        sb_pt.push_back(mk(8'd100, 8'd100, 1'b0, 1'b0, 1'b0));
        sb_pt.push_back(mk(8'd108, 8'd100, 1'b1, 1'b0, 1'b1));
        sb_err.push_back(1'b0);
        issue(10'd517, 8'd100, 8'd100, 8'd32, 8'd40);
        @(negedge clk);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("rom_adr_after_start", {22'd0, rom_adr}, 32'd517);
        @(posedge clk); @(negedge clk);
        chk("latency_not_yet", {31'd0, u_pt_if.pt_valid}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("latency_3", {31'd0, u_pt_if.pt_valid}, 32'd1);
        wait_done("basic_done", 40);

        // Clipping on both edges, then an unclipped point
        rom_mem[100] = w(1'b0, 1'b0, 8'd0, 8'd40);
        rom_mem[101] = w(1'b1, 1'b1, 8'd16, 8'd16);
        sb_pt.push_back(mk(8'd0, 8'd255, 1'b0, 1'b1, 1'b0));
        sb_pt.push_back(mk(8'd5, 8'd250, 1'b1, 1'b0, 1'b1));
        sb_err.push_back(1'b0);
        issue(10'd100, 8'd5, 8'd250, 8'd16, 8'd16);
        wait_done("clip_done", 40);

        // Backpressure on the second point
        rom_mem[200] = w(1'b0, 1'b0, 8'd10, 8'd10);
        rom_mem[201] = w(1'b0, 1'b1, 8'd20, 8'd30);
        rom_mem[202] = w(1'b1, 1'b1, 8'd50, 8'd5);
        sb_pt.push_back(mk(8'd50, 8'd60, 1'b0, 1'b0, 1'b0));
        sb_pt.push_back(mk(8'd60, 8'd80, 1'b1, 1'b0, 1'b0));
        sb_pt.push_back(mk(8'd90, 8'd55, 1'b1, 1'b0, 1'b1));
        sb_err.push_back(1'b0);
        issue(10'd200, 8'd50, 8'd60, 8'd10, 8'd10);
        wait_valid("bp_first_valid", 20);
        @(posedge clk); #1 u_pt_if.pt_ready = 1'b0;
        wait_valid("bp_second_valid", 20);
        repeat (5) @(posedge clk);
        #1 u_pt_if.pt_ready = 1'b1;
        wait_done("bp_done", 40);

        // Guard: no last flag, four points then done with err
        rom_mem[300] = w(1'b0, 1'b0, 8'd10, 8'd10);
        rom_mem[301] = w(1'b0, 1'b1, 8'd30, 8'd15);
        rom_mem[302] = w(1'b0, 1'b0, 8'd50, 8'd20);
        rom_mem[303] = w(1'b0, 1'b1, 8'd70, 8'd25);
        rom_mem[304] = w(1'b0, 1'b1, 8'd90, 8'd30);
        sb_pt.push_back(mk(8'd20, 8'd20, 1'b0, 1'b0, 1'b0));
        sb_pt.push_back(mk(8'd40, 8'd25, 1'b1, 1'b0, 1'b0));
        sb_pt.push_back(mk(8'd60, 8'd30, 1'b0, 1'b0, 1'b0));
        sb_pt.push_back(mk(8'd80, 8'd35, 1'b1, 1'b0, 1'b0));
        sb_err.push_back(1'b1);
        issue(10'd300, 8'd20, 8'd20, 8'd10, 8'd10);
        wait_done("guard_done", 60);
        repeat (8) @(posedge clk);

        // Address wrap and exact screen-edge values
        rom_mem[1023] = w(1'b0, 1'b1, 8'd0, 8'd0);
        rom_mem[0]    = w(1'b1, 1'b0, 8'd1, 8'd0);
        sb_pt.push_back(mk(8'd255, 8'd0, 1'b1, 1'b0, 1'b0));
        sb_pt.push_back(mk(8'd255, 8'd0, 1'b0, 1'b1, 1'b1));
        sb_err.push_back(1'b0);
        issue(10'd1023, 8'd255, 8'd0, 8'd0, 8'd0);
        wait_done("wrap_done", 40);

        // Second start while busy is ignored
        sb_pt.push_back(mk(8'd100, 8'd100, 1'b0, 1'b0, 1'b0));
        sb_pt.push_back(mk(8'd108, 8'd100, 1'b1, 1'b0, 1'b1));
        sb_err.push_back(1'b0);
        issue(10'd517, 8'd100, 8'd100, 8'd32, 8'd40);
        @(posedge clk); #1;
        img_adr = 10'd200; pos_x = 8'd7; pos_y = 8'd9; mid_x = 8'd1; mid_y = 8'd2;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("busy_start_done", 40);

        // Reset during EMIT: outputs clear at once, no done
        u_pt_if.pt_ready = 1'b0;
        issue(10'd517, 8'd100, 8'd100, 8'd32, 8'd40);
        wait_valid("rst_emit_valid", 20);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs",
            {9'd0, busy, done, err, rom_adr, u_pt_if.pt_valid, u_pt_if.pt_pen,
             u_pt_if.pt_clip, u_pt_if.pt_last},
            32'd0);
        chk("rst_mid_xy", {16'd0, u_pt_if.pt_x, u_pt_if.pt_y}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        u_pt_if.pt_ready = 1'b1;
        repeat (5) @(posedge clk);

        // Recovery after reset
        sb_pt.push_back(mk(8'd0, 8'd255, 1'b0, 1'b1, 1'b0));
        sb_pt.push_back(mk(8'd5, 8'd250, 1'b1, 1'b0, 1'b1));
        sb_err.push_back(1'b0);
        issue(10'd100, 8'd5, 8'd250, 8'd16, 8'd16);
        wait_done("recover_done", 40);
        repeat (5) @(posedge clk);

        chk("sb_points_drained", sb_pt.size(), 32'd0);
        chk("sb_done_drained", sb_err.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/rom_sprite_walker.md
Name: rom_sprite_walker

Overview:
Downstream consumer of the image constant package. Given an image start address, mid-point and screen position, it walks the vector-image ROM one point at a time and emits translated, clipped 8-bit XY points with pen state to the line/DAC drawing stage. Sits between the game/scene sequencer, which issues one sprite request at a time, and the vector drawer.

Parameters:
ADR_W, 10, ROM address width (covers image addresses up to 1023)
COORD_W, 8, screen coordinate width (0..255)
MAX_POINTS, 64, guard: maximum points walked per image before abort

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request pulse; sampled only in IDLE
img_adr  in  ADR_W  image start address (an ADR_*_START value)
pos_x  in  COORD_W  screen X at which the image mid-point is placed
pos_y  in  COORD_W  screen Y at which the image mid-point is placed
mid_x  in  COORD_W  image mid-point X (an *_MID_X value)
mid_y  in  COORD_W  image mid-point Y
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse when last point is accepted, or on abort
err  out  1  one-cycle pulse with done when MAX_POINTS is hit without a last flag
rom_adr  out  ADR_W  ROM read address
rom_data  in  18  ROM word, valid 1 cycle after rom_adr: [17] last, [16] pen, [15:8] x, [7:0] y
pt_valid  out  1  output point valid
pt_ready  in  1  drawer accepts the point
pt_x  out  COORD_W  translated X
pt_y  out  COORD_W  translated Y
pt_pen  out  1  1 = draw line to point, 0 = move beam only
pt_clip  out  1  point was clamped to the screen edge
pt_last  out  1  final point of the image

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, err=0, pt_valid=0, pt_x/pt_y=0, pt_pen/pt_clip/pt_last=0, rom_adr=0, point counter=0. Reset mid-walk aborts silently: no done and no err.
- States:
  - IDLE: on start=1, latch img_adr, pos, mid; set rom_adr=img_adr; busy=1; go to FETCH.
  - FETCH: ROM is addressed this cycle; go to WAIT.
  - WAIT: rom_data is valid; register the translated point; pt_valid=1; go to EMIT.
  - EMIT: hold all pt_* stable while pt_valid && !pt_ready.
    - On handshake with pt_last=1: done=1 next cycle, go to IDLE.
    - On handshake with counter = MAX_POINTS-1: done=1 and err=1, go to IDLE.
    - Otherwise: counter+1, rom_adr+1, go to FETCH.
- Throughput: one point per 3 cycles with pt_ready held high. Latency from start to first pt_valid = 3 cycles.
- Arithmetic: t = pos + rom_coord - mid, computed as 10-bit signed, per axis.
  - t<0: output 0, clip=1.
  - t>255: output 255, clip=1.
  - Otherwise output t[7:0].
  - pt_clip = OR of both axes.
- busy drops in the same cycle that done pulses. start while busy is ignored, with no latch and no side effect. A start in the cycle busy falls is not accepted; it must arrive in IDLE.
- rom_adr wraps modulo 2^ADR_W; this is not flagged.
- pt_ready asserted while pt_valid=0 has no effect.

Test Plan:
- Cursor at ADR 517, mid (32,40), pos (100,100). ROM[517]={pen 0,x 32,y 40}, ROM[518]={last 1,pen 1,x 40,y 40}, pt_ready=1 -> points (100,100,pen0) then (108,100,pen1,last); done 1 cycle after second handshake; err=0.
- Clipping: pos (5,250), mid (16,16), ROM word x=0,y=40 -> pt=(0,255), pt_clip=1. Word x=16,y=16 -> (5,250), clip=0.
- Backpressure: pt_ready low 5 cycles during point 2 -> pt_x/pt_y/pt_pen stable, rom_adr unchanged, no duplicate or lost points.
- Guard: MAX_POINTS=4, ROM with no last flag -> exactly 4 points, then done=1 with err=1, busy=0.
- Reset and start rules: rst_n low during EMIT -> all outputs 0 immediately, no done. A second start while busy -> ignored, first image completes unchanged.
